// File: rtl/tournament_pkg.sv
// rtl/tournament_pkg.sv - shared types and chooser helper for the tournament update buffer
package tournament_pkg;

  localparam int UPD_VLEN     = 64;
  localparam int UPD_GHR_BITS = 10;

  typedef enum logic [1:0] {
    CHOICE_HOLD   = 2'b00,
    CHOICE_GLOBAL = 2'b01,
    CHOICE_LOCAL  = 2'b10
  } choice_e;

  typedef struct packed {
    logic [UPD_VLEN-1:0]     pc;
    logic                    taken;
    logic [UPD_GHR_BITS-1:0] ghr;
    choice_e                 choice;
  } upd_entry_t;

  // Move the chooser toward whichever component alone got the outcome right.
  function automatic choice_e chooser_dir(input logic taken, input logic gbp, input logic lbp);
    if ((gbp == taken) && (lbp != taken)) begin
      return CHOICE_GLOBAL;
    end else if ((lbp == taken) && (gbp != taken)) begin
      return CHOICE_LOCAL;
    end else begin
      return CHOICE_HOLD;
    end
  endfunction

endpackage

// File: rtl/tournament_upd_fifo.sv
// rtl/tournament_upd_fifo.sv - DEPTH-entry update queue with pointers, count and flush
module tournament_upd_fifo
  import tournament_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  upd_entry_t push_data_i,
  input  logic       pop_i,
  output upd_entry_t head_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [CW-1:0] count_o
);

  upd_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow/underflow protection lives here so the top only has to express intent.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage, pointers and occupancy; flush drops any same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/tournament_update_buffer.sv
// rtl/tournament_update_buffer.sv - tournament predictor update queue; optional TOURNAMENT_UPD_BYPASS_EN
module tournament_update_buffer
  import tournament_pkg::*;
#(
  parameter int DEPTH    = 4,
  // Must match the widths baked into upd_entry_t.
  parameter int VLEN     = UPD_VLEN,
  parameter int GHR_BITS = UPD_GHR_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [VLEN-1:0]          res_pc_i,
  input  logic                     res_is_cond_i,
  input  logic                     res_taken_i,
  input  logic [GHR_BITS-1:0]      res_ghr_i,
  input  logic                     res_gbp_taken_i,
  input  logic                     res_lbp_taken_i,
  output logic                     upd_valid_o,
  input  logic                     upd_ready_i,
  output logic [VLEN-1:0]          upd_pc_o,
  output logic                     upd_taken_o,
  output logic [GHR_BITS-1:0]      upd_ghr_o,
  output logic [1:0]               upd_choice_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  upd_entry_t res_entry;
  upd_entry_t head_entry;
  upd_entry_t out_entry;
  logic       fifo_empty;
  logic       fifo_full;
  logic       accept;
  logic       bypass;
  logic       push;
  logic       pop;

  // Ready depends only on occupancy, never on upd_ready_i.
  assign res_ready_o = !fifo_full;
  assign accept      = res_valid_i && res_ready_o;

  // Build the queue entry, resolving the chooser direction at enqueue time.
  always_comb begin
    res_entry        = '0;
    res_entry.pc     = res_pc_i;
    res_entry.taken  = res_taken_i;
    res_entry.ghr    = res_ghr_i;
    res_entry.choice = chooser_dir(res_taken_i, res_gbp_taken_i, res_lbp_taken_i);
  end

`ifdef TOURNAMENT_UPD_BYPASS_EN
  // An empty queue with a ready predictor lets a conditional go straight through.
  assign bypass = fifo_empty && res_valid_i && res_is_cond_i && upd_ready_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Jumps are consumed but never queued; bypassed entries skip the queue.
  assign push = accept && res_is_cond_i && !bypass;
  assign pop  = upd_ready_i && !fifo_empty;

  tournament_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (push),
    .push_data_i (res_entry),
    .pop_i       (pop),
    .head_o      (head_entry),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (count_o)
  );

  // Output mux: bypass entry, else queue head, else zeros so idle outputs stay clean.
  always_comb begin
    out_entry = '0;
    if (bypass) begin
      out_entry = res_entry;
    end else if (!fifo_empty) begin
      out_entry = head_entry;
    end
  end

  assign upd_valid_o  = !fifo_empty || bypass;
  assign upd_pc_o     = out_entry.pc;
  assign upd_taken_o  = out_entry.taken;
  assign upd_ghr_o    = out_entry.ghr;
  assign upd_choice_o = out_entry.choice;

endmodule

// File: tb/tb_tournament_update_buffer.sv
// tb/tb_tournament_update_buffer.sv - directed self-checking bench for tournament_update_buffer
module tb_tournament_update_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [63:0] res_pc_i;
  logic        res_is_cond_i;
  logic        res_taken_i;
  logic [9:0]  res_ghr_i;
  logic        res_gbp_taken_i;
  logic        res_lbp_taken_i;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic [63:0] upd_pc_o;
  logic        upd_taken_o;
  logic [9:0]  upd_ghr_o;
  logic [1:0]  upd_choice_o;
  logic [2:0]  count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  tournament_update_buffer #(.DEPTH(4), .VLEN(64), .GHR_BITS(10)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .res_valid_i     (res_valid_i),
    .res_ready_o     (res_ready_o),
    .res_pc_i        (res_pc_i),
    .res_is_cond_i   (res_is_cond_i),
    .res_taken_i     (res_taken_i),
    .res_ghr_i       (res_ghr_i),
    .res_gbp_taken_i (res_gbp_taken_i),
    .res_lbp_taken_i (res_lbp_taken_i),
    .upd_valid_o     (upd_valid_o),
    .upd_ready_i     (upd_ready_i),
    .upd_pc_o        (upd_pc_o),
    .upd_taken_o     (upd_taken_o),
    .upd_ghr_o       (upd_ghr_o),
    .upd_choice_o    (upd_choice_o),
    .count_o         (count_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_res(input logic v, input logic [63:0] pc, input logic cond,
                           input logic tk, input logic [9:0] ghr, input logic g, input logic l);
    res_valid_i     = v;
    res_pc_i        = pc;
    res_is_cond_i   = cond;
    res_taken_i     = tk;
    res_ghr_i       = ghr;
    res_gbp_taken_i = g;
    res_lbp_taken_i = l;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    flush_i = 1'b0;
    upd_ready_i = 1'b0;
    drive_res(1'b0, 64'h0, 1'b0, 1'b0, 10'h0, 1'b0, 1'b0);
    tick();
    tick();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", upd_valid_o); end
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", res_ready_o); end
    checks++; if ({upd_pc_o, upd_taken_o, upd_ghr_o, upd_choice_o} !== 77'd0) begin
      errors++; $display("FAIL reset_data got pc=%h t=%b g=%h c=%b exp=0", upd_pc_o, upd_taken_o, upd_ghr_o, upd_choice_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    upd_ready_i = 1'b1;
    drive_res(1'b1, 64'h8000_0040, 1'b1, 1'b1, 10'h2a5, 1'b1, 1'b0);
    #1;
`ifdef TOURNAMENT_UPD_BYPASS_EN
    checks++; if (upd_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", upd_valid_o); end
    checks++; if (upd_choice_o !== 2'b01) begin errors++; $display("FAIL bypass_choice got=%b exp=01", upd_choice_o); end
    checks++; if (upd_pc_o !== 64'h8000_0040) begin errors++; $display("FAIL bypass_pc got=%h exp=80000040", upd_pc_o); end
    tick();
    res_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL bypass_count got=%0d exp=0", count_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_after_valid got=%b exp=0", upd_valid_o); end
`else
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL single_same_cycle_valid got=%b exp=0", upd_valid_o); end
    tick();
    res_valid_i = 1'b0;
    #1;
    checks++; if (upd_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", upd_valid_o); end
    checks++; if (upd_choice_o !== 2'b01) begin errors++; $display("FAIL single_choice got=%b exp=01", upd_choice_o); end
    checks++; if (upd_taken_o !== 1'b1) begin errors++; $display("FAIL single_taken got=%b exp=1", upd_taken_o); end
    checks++; if (upd_pc_o !== 64'h8000_0040) begin errors++; $display("FAIL single_pc got=%h exp=80000040", upd_pc_o); end
    checks++; if (upd_ghr_o !== 10'h2a5) begin errors++; $display("FAIL single_ghr got=%h exp=2a5", upd_ghr_o); end
    checks++; if (count_o !== 3'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", count_o); end
    tick();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL single_count0 got=%0d exp=0", count_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", upd_valid_o); end
`endif
  endtask

  task automatic test_jump();
    upd_ready_i = 1'b1;
    drive_res(1'b1, 64'h100, 1'b0, 1'b1, 10'h0, 1'b1, 1'b1);
    #1;
    checks++; if (res_ready_o !== 1'b1) begin errors++; $display("FAIL jump_ready got=%b exp=1", res_ready_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL jump_valid0 got=%b exp=0", upd_valid_o); end
    tick();
    res_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL jump_count got=%0d exp=0", count_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL jump_valid1 got=%b exp=0", upd_valid_o); end
    tick();
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL jump_valid2 got=%b exp=0", upd_valid_o); end
  endtask

  task automatic test_full();
    logic [63:0] pcs [4] = '{64'h1000, 64'h1004, 64'h1008, 64'h100c};
    logic        tks [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        gs  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        ls  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [9:0]  ghs [4] = '{10'h001, 10'h155, 10'h2aa, 10'h3ff};
    logic [1:0]  chs [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
    upd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_res(1'b1, pcs[i], 1'b1, tks[i], ghs[i], gs[i], ls[i]);
      tick();
    end
    drive_res(1'b1, 64'hdead, 1'b1, 1'b1, 10'h0, 1'b1, 1'b0);
    #1;
    checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count_o); end
    checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", res_ready_o); end
    for (int s = 0; s < 2; s++) begin
      tick();
      checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_hold_count got=%0d exp=4", count_o); end
      checks++; if (upd_pc_o !== 64'h1000 || upd_valid_o !== 1'b1) begin
        errors++; $display("FAIL full_stall_stable got pc=%h v=%b exp pc=1000 v=1", upd_pc_o, upd_valid_o);
      end
    end
    res_valid_i = 1'b0;
    upd_ready_i = 1'b1;
    #1;
    checks++; if (res_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready_with_pop got=%b exp=0", res_ready_o); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (upd_valid_o !== 1'b1 || upd_pc_o !== pcs[i] || upd_taken_o !== tks[i] ||
                    upd_ghr_o !== ghs[i] || upd_choice_o !== chs[i]) begin
        errors++; $display("FAIL drain_%0d got v=%b pc=%h t=%b g=%h c=%b exp pc=%h t=%b g=%h c=%b", i,
                           upd_valid_o, upd_pc_o, upd_taken_o, upd_ghr_o, upd_choice_o, pcs[i], tks[i], ghs[i], chs[i]);
      end
      tick();
    end
    checks++; if (count_o !== 3'd0 || upd_valid_o !== 1'b0) begin
      errors++; $display("FAIL drain_empty got cnt=%0d v=%b exp cnt=0 v=0", count_o, upd_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] chs [8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    upd_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_res(1'b1, 64'h2000 + 64'(4 * k), 1'b1, k[0], 10'(k), 1'b1, 1'b0);
      tick();
    end
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL b2b_prefill got=%0d exp=2", count_o); end
    upd_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive_res(1'b1, 64'h2000 + 64'(4 * (k + 2)), 1'b1, k[0], 10'(k + 2), 1'b1, 1'b0);
      #1;
      checks++; if (upd_pc_o !== 64'h2000 + 64'(4 * k) || upd_choice_o !== chs[k]) begin
        errors++; $display("FAIL b2b_head_%0d got pc=%h c=%b exp pc=%h c=%b", k, upd_pc_o, upd_choice_o,
                           64'h2000 + 64'(4 * k), chs[k]);
      end
      tick();
      checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=2", k, count_o); end
    end
    res_valid_i = 1'b0;
    #1;
    for (int k = 6; k < 8; k++) begin
      checks++; if (upd_pc_o !== 64'h2000 + 64'(4 * k) || upd_ghr_o !== 10'(k)) begin
        errors++; $display("FAIL b2b_tail_%0d got pc=%h g=%h exp pc=%h g=%h", k, upd_pc_o, upd_ghr_o,
                           64'h2000 + 64'(4 * k), 10'(k));
      end
      tick();
    end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL b2b_empty got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    upd_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_res(1'b1, 64'h3000 + 64'(4 * k), 1'b1, 1'b1, 10'h0, 1'b0, 1'b1);
      tick();
    end
    checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL flush_prefill got=%0d exp=3", count_o); end
    flush_i = 1'b1;
    drive_res(1'b1, 64'h3ffc, 1'b1, 1'b1, 10'h0, 1'b1, 1'b0);
    tick();
    flush_i = 1'b0;
    res_valid_i = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
    checks++; if (upd_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", upd_valid_o); end
    upd_ready_i = 1'b1;
    tick();
    checks++; if (upd_valid_o !== 1'b0 || count_o !== 3'd0) begin
      errors++; $display("FAIL flush_push_absent got v=%b cnt=%0d exp v=0 cnt=0", upd_valid_o, count_o);
    end
  endtask

  task automatic test_reset_mid();
    upd_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_res(1'b1, 64'h4000 + 64'(4 * k), 1'b1, 1'b0, 10'h0, 1'b0, 1'b1);
      tick();
    end
    res_valid_i = 1'b0;
    checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL midrst_prefill got=%0d exp=2", count_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (count_o !== 3'd0 || upd_valid_o !== 1'b0 || res_ready_o !== 1'b1 || upd_pc_o !== 64'h0) begin
      errors++; $display("FAIL midrst_state got cnt=%0d v=%b r=%b pc=%h exp cnt=0 v=0 r=1 pc=0",
                         count_o, upd_valid_o, res_ready_o, upd_pc_o);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL midrst_after got=%0d exp=0", count_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_jump();
    test_full();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
